uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one uart_top transmitter, range 2..8.
REQ-002 Parameter START_TIMEOUT, default 16: maximum LAUNCH cycles to wait for uart_tx_busy to rise.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req  input  N_REQ  per-requester transmit request; level, held until ack.
REQ-006 req_wdata  input  N_REQ*8  per-requester byte; requester i uses bits [8i+7:8i].
REQ-007 req_tlen  input  N_REQ*2  per-requester length code (00=5b, 01=6b, 10=7b, 11=8b).
REQ-008 req_parity_en  input  N_REQ  per-requester parity enable.
REQ-009 req_parity_type  input  N_REQ  per-requester parity type (0=even, 1=odd).
REQ-010 gnt  output  N_REQ  one-hot grant; high while the winner's frame is in flight.
REQ-011 ack  output  N_REQ  one-cycle pulse to the winner when its frame has completed.
REQ-012 err  output  N_REQ  one-cycle pulse to the winner when the UART failed to start.
REQ-013 uart_wr_en, uart_wdata[7:0], uart_tlen[1:0], uart_parity_en, uart_parity_type  outputs  to uart_top.
REQ-014 uart_tx_busy  input  1  high while uart_top shifts a frame out on TXD.
REQ-015 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-016 FSM states SHALL be IDLE, LAUNCH and WAIT_DONE, with a 2-bit state register.
REQ-017 In IDLE with any eligible req bit, winner = first requesting index at or after rr_ptr, circular; go to LAUNCH on the next edge.
REQ-018 A requester whose ack bit is high in the current cycle SHALL be ineligible in that cycle.
REQ-019 On the IDLE->LAUNCH edge, the winner's wdata, tlen, parity_en and parity_type SHALL be latched into the uart_* outputs.
REQ-020 The latched uart_* configuration SHALL stay constant through LAUNCH and WAIT_DONE, and SHALL hold its last value in IDLE.
REQ-021 gnt[winner] SHALL be high in LAUNCH and WAIT_DONE, and all gnt bits SHALL be low in IDLE.
REQ-022 uart_wr_en SHALL be high in every LAUNCH cycle and low in all other states.
REQ-023 LAUNCH with uart_tx_busy=1 SHALL go to WAIT_DONE.
REQ-024 A timeout counter SHALL count LAUNCH cycles; if it reaches START_TIMEOUT with uart_tx_busy still 0: err[winner] pulses for one cycle, then IDLE.
REQ-025 WAIT_DONE with uart_tx_busy=0 SHALL go to IDLE, with ack[winner] high for exactly the first IDLE cycle.
REQ-026 On completion or error, rr_ptr SHALL be set to (winner+1) mod N_REQ; rr_ptr SHALL be unchanged otherwise.
REQ-027 Dropping req[winner] after grant SHALL NOT abort the frame; ack is still issued.
REQ-028 Changes on non-winner req or data inputs mid-frame SHALL have no effect on the uart_* outputs.
REQ-029 ack and err SHALL never both be high, and at most one bit of each SHALL be high at a time.
REQ-030 Back-to-back frames: minimum spacing from ack to the next uart_wr_en rise SHALL be 1 cycle (IDLE, then LAUNCH).

Reset
REQ-031 rst_n=0 SHALL immediately force state=IDLE and rr_ptr=0.
REQ-032 rst_n=0 SHALL immediately clear the timeout counter and force gnt, ack, err, uart_wr_en and busy to 0.
REQ-033 rst_n=0 SHALL immediately set uart_wdata=0, uart_tlen=2'b11, uart_parity_en=0 and uart_parity_type=0.
REQ-034 Reset asserted mid-frame SHALL abandon the frame without issuing ack or err.
REQ-035 The first arbitration after reset release SHALL occur on the first clk edge with rst_n=1.

Verification
REQ-036 Single request: req=0001, wdata0=8'hEB, tlen0=11 with a loopback uart_top -> gnt=0001, uart_wdata=EB, one ack[0] pulse, RX rdata=EB.
REQ-037 Simultaneous requests: req=1111 held, each requester re-requests after ack -> grant order 0,1,2,3,0, and no requester is granted twice in a row.
REQ-038 Per-requester config: req1 {tlen=10, parity_en=1, type=1, 8'hEA} and req2 {tlen=00, parity_en=0, 8'hEB} -> RX rdata 8'h6A then 8'h0B, parity_err=0, and config stable during each frame.
REQ-039 Start timeout: uart_tx_busy stub tied 0, req=0100 -> uart_wr_en high 16 cycles, err[2] pulses once, no ack, and rr_ptr=3.
REQ-040 Mid-frame events: drop req[0] during WAIT_DONE -> ack[0] still pulses.
REQ-041 Reset mid-frame: assert rst_n=0 during WAIT_DONE -> all outputs reach reset values at once, with no ack or err pulse.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets N_REQ requesters share one uart_top transmitter.
// Latency: grant, uart_wr_en and latched config appear on the edge after a request is seen in IDLE; ack/err one cycle after frame end.
// Backpressure: requests are level-held until ack; only one frame in flight, others wait in IDLE arbitration.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   req[N_REQ]                    per-requester transmit request (level)
//   req_wdata[N_REQ*8]            per-requester byte, requester i at [8i+7:8i]
//   req_tlen[N_REQ*2]             per-requester length code (00=5b .. 11=8b)
//   req_parity_en/_type[N_REQ]    per-requester parity enable / type (1=odd)
//   gnt[N_REQ]                    one-hot grant, high while the winner's frame is in flight
//   ack[N_REQ], err[N_REQ]        one-cycle completion / start-failure pulse to the winner
//   uart_wr_en, uart_wdata, uart_tlen, uart_parity_en, uart_parity_type   to uart_top
//   uart_tx_busy                  from uart_top, high while a frame is shifted out
//   busy                          high whenever the FSM is not in IDLE
module uart_tx_arbiter #(
  parameter int N_REQ         = 4,
  parameter int START_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ*8-1:0]   req_wdata,
  input  logic [N_REQ*2-1:0]   req_tlen,
  input  logic [N_REQ-1:0]     req_parity_en,
  input  logic [N_REQ-1:0]     req_parity_type,
  output logic [N_REQ-1:0]     gnt,
  output logic [N_REQ-1:0]     ack,
  output logic [N_REQ-1:0]     err,
  output logic                 uart_wr_en,
  output logic [7:0]           uart_wdata,
  output logic [1:0]           uart_tlen,
  output logic                 uart_parity_en,
  output logic                 uart_parity_type,
  input  logic                 uart_tx_busy,
  output logic                 busy
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT + 1) : 1;
  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t          state;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   win_idx;
  logic [CW-1:0]   tmo_cnt;

  logic [N_REQ-1:0] elig;
  logic             pick_vld;
  logic [PW-1:0]    pick_idx;
  logic [PW-1:0]    cand_idx;
  logic [PW-1:0]    next_ptr;

  // The requester being acked this cycle still holds req high for one more
  // cycle; masking it keeps it from being re-granted before it sees the ack.
  assign elig = req & ~ack;

  // Circular search starting at rr_ptr: the first eligible index wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand_idx = PW'((int'(rr_ptr) + k) % N_REQ);
      if (!pick_vld && elig[cand_idx]) begin
        pick_vld = 1'b1;
        pick_idx = cand_idx;
      end
    end
  end

  // Pointer moves just past the finished winner, so it drops to lowest priority.
  assign next_ptr = (win_idx == PW'(N_REQ - 1)) ? '0 : win_idx + PW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      rr_ptr           <= '0;
      win_idx          <= '0;
      tmo_cnt          <= '0;
      gnt              <= '0;
      ack              <= '0;
      err              <= '0;
      uart_wr_en       <= 1'b0;
      uart_wdata       <= 8'h00;
      uart_tlen        <= 2'b11;
      uart_parity_en   <= 1'b0;
      uart_parity_type <= 1'b0;
      busy             <= 1'b0;
    end else begin
      // ack/err are single-cycle pulses
      ack <= '0;
      err <= '0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            state            <= LAUNCH;
            win_idx          <= pick_idx;
            tmo_cnt          <= '0;
            gnt              <= ONE_HOT0 << pick_idx;
            uart_wr_en       <= 1'b1;
            busy             <= 1'b1;
            // Config is captured once here so later changes on any req
            // input cannot disturb the frame in flight.
            uart_wdata       <= req_wdata[int'(pick_idx)*8 +: 8];
            uart_tlen        <= req_tlen[int'(pick_idx)*2 +: 2];
            uart_parity_en   <= req_parity_en[pick_idx];
            uart_parity_type <= req_parity_type[pick_idx];
          end
        end

        LAUNCH: begin
          if (uart_tx_busy) begin
            state      <= WAIT_DONE;
            uart_wr_en <= 1'b0;
          end else if (tmo_cnt == CW'(START_TIMEOUT - 1)) begin
            // This is the START_TIMEOUT-th LAUNCH cycle without a start.
            state      <= IDLE;
            err        <= gnt;
            gnt        <= '0;
            uart_wr_en <= 1'b0;
            busy       <= 1'b0;
            rr_ptr     <= next_ptr;
          end else begin
            tmo_cnt <= tmo_cnt + CW'(1);
          end
        end

        WAIT_DONE: begin
          // The winner's req is ignored here: dropping it does not abort.
          if (!uart_tx_busy) begin
            state  <= IDLE;
            ack    <= gnt;
            gnt    <= '0;
            busy   <= 1'b0;
            rr_ptr <= next_ptr;
          end
        end

        default: begin
          state      <= IDLE;
          gnt        <= '0;
          uart_wr_en <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed stimulus with a scoreboard of expected
// grants, acks, errs and received bytes, checked by a separate negedge monitor
// against a simple uart_top stand-in (busy a few cycles, delivers masked byte).
module tb_uart_tx_arbiter;
  localparam int N   = 4;
  localparam int TMO = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req;
  logic [N*8-1:0]    req_wdata;
  logic [N*2-1:0]    req_tlen;
  logic [N-1:0]      req_parity_en;
  logic [N-1:0]      req_parity_type;
  logic [N-1:0]      gnt, ack, err;
  logic              uart_wr_en;
  logic [7:0]        uart_wdata;
  logic [1:0]        uart_tlen;
  logic              uart_parity_en, uart_parity_type;
  logic              uart_tx_busy;
  logic              busy;

  uart_tx_arbiter #(.N_REQ(N), .START_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_wdata(req_wdata), .req_tlen(req_tlen),
    .req_parity_en(req_parity_en), .req_parity_type(req_parity_type),
    .gnt(gnt), .ack(ack), .err(err), .uart_wr_en(uart_wr_en), .uart_wdata(uart_wdata),
    .uart_tlen(uart_tlen), .uart_parity_en(uart_parity_en), .uart_parity_type(uart_parity_type),
    .uart_tx_busy(uart_tx_busy), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- uart_top stand-in ----------------
  logic       stub_dead;
  int         stub_cnt;
  logic [7:0] stub_dat;
  logic [1:0] stub_tlen;
  logic       rx_vld;
  logic [7:0] rx_dat;

  function automatic logic [7:0] len_mask(input logic [1:0] t);
    case (t)
      2'b00:   return 8'h1F;
      2'b01:   return 8'h3F;
      2'b10:   return 8'h7F;
      default: return 8'hFF;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uart_tx_busy <= 1'b0;
      stub_cnt     <= 0;
      rx_vld       <= 1'b0;
      rx_dat       <= 8'h00;
      stub_dat     <= 8'h00;
      stub_tlen    <= 2'b11;
    end else begin
      rx_vld <= 1'b0;
      if (!uart_tx_busy) begin
        if (uart_wr_en && !stub_dead) begin
          uart_tx_busy <= 1'b1;
          stub_cnt     <= 4;
          stub_dat     <= uart_wdata;
          stub_tlen    <= uart_tlen;
        end
      end else if (stub_cnt == 1) begin
        uart_tx_busy <= 1'b0;
        rx_vld       <= 1'b1;
        rx_dat       <= stub_dat & len_mask(stub_tlen);
      end else begin
        stub_cnt <= stub_cnt - 1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    int         idx;
    logic [7:0] d;
    logic [1:0] t;
    logic       pe;
    logic       pt;
    int         wr_cyc;
    bit         gap;
  } gnt_t;

  gnt_t       exp_gnt[$];
  int         exp_ack[$];
  int         exp_err[$];
  logic [7:0] exp_rx[$];

  task automatic set_cfg(input int i, input logic [7:0] d, input logic [1:0] t,
                         input logic pe, input logic pt);
    req_wdata[i*8 +: 8]  = d;
    req_tlen[i*2 +: 2]   = t;
    req_parity_en[i]     = pe;
    req_parity_type[i]   = pt;
  endtask

  // kind: 0 = completes (ack + rx byte), 1 = start timeout (err), 2 = aborted by reset
  task automatic push_frame(input int i, input int kind, input bit gap, input logic [7:0] rx);
    gnt_t g;
    g.idx    = i;
    g.d      = req_wdata[i*8 +: 8];
    g.t      = req_tlen[i*2 +: 2];
    g.pe     = req_parity_en[i];
    g.pt     = req_parity_type[i];
    g.wr_cyc = (kind == 1) ? TMO : 2;
    g.gap    = gap;
    exp_gnt.push_back(g);
    if (kind == 0) begin
      exp_ack.push_back(i);
      exp_rx.push_back(rx);
    end else if (kind == 1) begin
      exp_err.push_back(i);
    end
  endtask

  // ---------------- monitor ----------------
  int         cyc = 0;
  int         last_ack_cyc = 0;
  int         wr_cnt = 0;
  bit         in_frame = 0;
  bit         stable = 0;
  logic [N-1:0] prev_gnt = '0;
  gnt_t       cur;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      in_frame = 0;
      prev_gnt = '0;
    end else begin
      if (gnt != 0 && prev_gnt == 0) begin
        if (exp_gnt.size() == 0) begin
          chk("unexpected_grant", 32'(gnt), 32'd0);
        end else begin
          cur = exp_gnt.pop_front();
          chk("gnt_vec", 32'(gnt), 32'(1) << cur.idx);
          chk("cfg_wdata", 32'(uart_wdata), 32'(cur.d));
          chk("cfg_tlen", 32'(uart_tlen), 32'(cur.t));
          chk("cfg_parity", 32'({uart_parity_en, uart_parity_type}), 32'({cur.pe, cur.pt}));
          if (cur.gap) chk("b2b_gap", 32'(cyc - last_ack_cyc), 32'd1);
          in_frame = 1;
          wr_cnt   = 0;
          stable   = 1;
        end
      end
      if (in_frame) begin
        if (uart_wr_en) wr_cnt++;
        if ({uart_wdata, uart_tlen, uart_parity_en, uart_parity_type} !==
            {cur.d, cur.t, cur.pe, cur.pt}) stable = 0;
      end
      if (gnt == 0 && prev_gnt != 0 && in_frame) begin
        chk("wr_en_cycles", 32'(wr_cnt), 32'(cur.wr_cyc));
        chk("cfg_stable", 32'(stable), 32'd1);
        in_frame = 0;
      end
      prev_gnt = gnt;

      if (ack != 0 || err != 0) chk("ack_err_excl", 32'(|ack && |err), 32'd0);
      if (ack != 0) begin
        last_ack_cyc = cyc;
        if (exp_ack.size() == 0) chk("unexpected_ack", 32'(ack), 32'd0);
        else chk("ack_vec", 32'(ack), 32'(1) << exp_ack.pop_front());
      end
      if (err != 0) begin
        if (exp_err.size() == 0) chk("unexpected_err", 32'(err), 32'd0);
        else chk("err_vec", 32'(err), 32'(1) << exp_err.pop_front());
      end
      if (rx_vld) begin
        if (exp_rx.size() == 0) chk("unexpected_rx", 32'(rx_dat), 32'd0);
        else chk("rx_rdata", 32'(rx_dat), 32'(exp_rx.pop_front()));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_evt(input bit is_err, input int i);
    bit seen = 0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (is_err ? err[i] : ack[i]) seen = 1;
    end
    chk(is_err ? "wait_err" : "wait_ack", 32'(seen), 32'd1);
  endtask

  task automatic wait_wait_done();
    bit seen = 0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (gnt != 0 && !uart_wr_en) seen = 1;
    end
    chk("wait_wait_done", 32'(seen), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_gnt"}, 32'(gnt), 32'd0);
    chk({tag, "_ack_err"}, 32'({ack, err}), 32'd0);
    chk({tag, "_wr_en_busy"}, 32'({uart_wr_en, busy}), 32'd0);
    chk({tag, "_wdata"}, 32'(uart_wdata), 32'h00);
    chk({tag, "_tlen"}, 32'(uart_tlen), 32'd3);
    chk({tag, "_parity"}, 32'({uart_parity_en, uart_parity_type}), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    req = '0; req_wdata = '0; req_tlen = '0; req_parity_en = '0; req_parity_type = '0;
    stub_dead = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");

    // Single request, held during reset: first arbitration on first edge after release.
    set_cfg(0, 8'hEB, 2'b11, 1'b0, 1'b0);
    push_frame(0, 0, 0, 8'hEB);
    req = 4'b0001;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_arb_gnt", 32'(gnt), 32'h1);
    wait_evt(0, 0);
    req = '0;
    repeat (3) @(negedge clk);

    // All four request and keep requesting: 0,1,2,3,0 back-to-back.
    do_reset();
    for (int i = 0; i < N; i++) set_cfg(i, 8'h10 + 8'(i), 2'b11, 1'b0, 1'b0);
    push_frame(0, 0, 0, 8'h10);
    push_frame(1, 0, 1, 8'h11);
    push_frame(2, 0, 1, 8'h12);
    push_frame(3, 0, 1, 8'h13);
    push_frame(0, 0, 1, 8'h10);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) wait_evt(0, k % N);
    req = '0;
    repeat (3) @(negedge clk);

    // Per-requester configuration: 7-bit odd parity, then 5-bit no parity.
    do_reset();
    set_cfg(1, 8'hEA, 2'b10, 1'b1, 1'b1);
    set_cfg(2, 8'hEB, 2'b00, 1'b0, 1'b0);
    push_frame(1, 0, 0, 8'h6A);
    push_frame(2, 0, 1, 8'h0B);
    req = 4'b0110;
    wait_evt(0, 1);
    req[1] = 1'b0;
    set_cfg(1, 8'h00, 2'b01, 1'b0, 1'b0);   // non-winner changes mid-frame
    wait_evt(0, 2);
    req = '0;
    repeat (3) @(negedge clk);

    // Start timeout: UART never goes busy.
    do_reset();
    stub_dead = 1'b1;
    set_cfg(2, 8'h5A, 2'b11, 1'b0, 1'b0);
    push_frame(2, 1, 0, 8'h00);
    req = 4'b0100;
    wait_evt(1, 2);
    req = '0;
    stub_dead = 1'b0;
    repeat (2) @(negedge clk);
    // rr_ptr is now 3, so requester 3 beats requester 0.
    set_cfg(3, 8'hC3, 2'b11, 1'b0, 1'b0);
    set_cfg(0, 8'h3C, 2'b11, 1'b0, 1'b0);
    push_frame(3, 0, 0, 8'hC3);
    req = 4'b1001;
    wait_evt(0, 3);
    req = '0;
    repeat (3) @(negedge clk);

    // Winner drops req during WAIT_DONE: ack still issued.
    set_cfg(0, 8'h96, 2'b11, 1'b1, 1'b1);
    push_frame(0, 0, 0, 8'h96);
    req = 4'b0001;
    wait_wait_done();
    req = '0;
    wait_evt(0, 0);
    repeat (3) @(negedge clk);

    // Reset during WAIT_DONE: outputs go to reset values at once, no ack/err.
    set_cfg(1, 8'h77, 2'b11, 1'b0, 1'b0);
    push_frame(1, 2, 0, 8'h00);
    req = 4'b0010;
    wait_wait_done();
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("midrst");
    req = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    chk("left_gnt", 32'(exp_gnt.size()), 32'd0);
    chk("left_ack", 32'(exp_ack.size()), 32'd0);
    chk("left_err", 32'(exp_err.size()), 32'd0);
    chk("left_rx", 32'(exp_rx.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, tests=%0d", tests);
    $fatal(1, "global timeout");
  end

endmodule
